cnn_cell_euler_iter: RTL and testbench
======================================

// Module: cnn_cell_euler_iter
// PURPOSE
// Iterative CNN (cellular nonlinear network) cell. It runs n_iter forward-Euler steps of
//   dx = -x + sum(A_k*y_k) + sum(B_k*u_k) + I
// on its own state x, then applies the clamp output y = sat(x, -1, +1).
// The block uses one multiply pair, shared over TAPS neighbourhood taps.
// It sits in the cell array under the array controller, which supplies the neighbour outputs between steps.
// PARAMETERS
// WIDTH     9   coefficient/input/bias width, signed, FRAC fraction bits
// TAPS      9   neighbourhood taps (3x3); centre tap is index TAPS/2
// FRAC      4   fraction bits of every fixed-point quantity
// DT_SHIFT  1   Euler step h = 2^-DT_SHIFT, applied as an arithmetic right shift
// ITW       8   width of iteration count
// PORTS
// clk       in   1              clock, rising edge
// reset     in   1              synchronous, active-high
// start     in   1              1-cycle request; sampled only in IDLE
// n_iter    in   ITW            Euler steps to run; sampled with start
// a_flat    in   TAPS*WIDTH     feedback template A, tap k at [k*WIDTH +: WIDTH]
// b_flat    in   TAPS*WIDTH     control template B
// u_flat    in   TAPS*WIDTH     neighbourhood inputs U
// bias      in   WIDTH          I
// x_init    in   2*WIDTH        initial state
// y_nbr     in   TAPS*2*WIDTH   neighbour outputs, tap k at [k*2*WIDTH +: 2*WIDTH]
// busy      out  1              high from the cycle after start up to and including the cycle before done
// step      out  1              1-cycle pulse after each Euler update
// done      out  1              1-cycle pulse when the run completes
// x_out     out  2*WIDTH        current state x
// y_out     out  2*WIDTH        sat(x) to [-2^FRAC, +2^FRAC]
// BEHAVIOUR
// - Reset: IDLE; busy=0, step=0, done=0, x_out=0, y_out=0.
//   All internal registers (accumulator, tap counter, iteration counter) are cleared.
//   Reset mid-run aborts the run with no done pulse.
// - FSM: IDLE -> LOAD -> {MAC -> UPD}* -> FIN -> IDLE.
// - IDLE: when start=1, latch a_flat, b_flat, u_flat, bias, n_iter and x_init into x, then go to LOAD.
//   start in any other state is ignored.
// - LOAD (1 cycle):
//   - latch y_nbr into the tap register bank;
//   - acc <= 0;
//   - if n_iter==0, go to FIN; otherwise go to MAC with k=0.
// - MAC (TAPS cycles): acc += (A_k*Yreg_k >>> FRAC) + (B_k*U_k >>> FRAC); k++ each cycle.
//   - Shifts are arithmetic, rounding toward -inf.
//   - acc width is 3*WIDTH+$clog2(2*TAPS)+1; it must never overflow.
// - UPD (1 cycle):
//   - d = acc + I - x; x <= sat2W(x + (d >>> DT_SHIFT)), saturating to the signed 2*WIDTH range.
//   - step=1; iter++.
//   - Re-latch y_nbr into the tap register bank (the array controller must present the new neighbour y by this edge).
//   - acc <= 0; k <= 0.
//   - Go to FIN if iter==n_iter, else go to MAC.
// - FIN (1 cycle): done=1; return to IDLE.
// - Latency: start -> done = 2 + n_iter*(TAPS+1) cycles (n_iter=0 gives 2).
// - y_out is always sat(x_out) and is registered together with x_out.
// - x_out and y_out hold their values in IDLE until the next start.
// - Template, U and bias changes during a run have no effect; y_nbr is sampled only in LOAD and UPD.
// TESTING
// T1: A=B=0, I=16, x_init=0, DT_SHIFT=1, n_iter=5
//     -> x after each step = 8, 12, 14, 15, 15; y_out=15; done at cycle 52.
// T2: Same as T1 with x_init=100, n_iter=1 -> x = 100 + ((16-100)>>>1) = 58; y_out=16 (clamped).
// T3: A centre=32 (2.0), y_nbr centre=16, all other taps 0, B=0, I=0, x_init=0, n_iter=1
//     -> acc=32, x=16, y=16.
// T4: n_iter=0, x_init=-40 -> done 2 cycles after start; x_out=-40, y_out=-16; no step pulse.
// T5: Assert reset at the 5th MAC cycle -> next cycle busy=0, x_out=0, no done.
//     A start pulse while busy is ignored; the run result is unchanged.
// T6: A=B all 255 (max), U and y_nbr at positive max, I=255
//     -> x saturates at 2^(2*WIDTH-1)-1 with no wrap; y_out=16.

Source files
------------

// File: rtl/cnn_cell_euler_iter.sv
// Iterative CNN cell: n_iter forward-Euler steps of dx = -x + sum(A*y) + sum(B*u) + I, then y = sat(x).
// Latency: start -> done = 2 + n_iter*(TAPS+1) cycles; one shared multiply pair walks the taps.
// No backpressure: start is only honoured in IDLE; neighbour y is sampled in LOAD and UPD.
module cnn_cell_euler_iter #(
   parameter int WIDTH    = 9,
   parameter int TAPS     = 9,
   parameter int FRAC     = 4,
   parameter int DT_SHIFT = 1,
   parameter int ITW      = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ITW-1:0]            n_iter,
   input  logic [TAPS*WIDTH-1:0]     a_flat,
   input  logic [TAPS*WIDTH-1:0]     b_flat,
   input  logic [TAPS*WIDTH-1:0]     u_flat,
   input  logic [WIDTH-1:0]          bias,
   input  logic [2*WIDTH-1:0]        x_init,
   input  logic [TAPS*2*WIDTH-1:0]   y_nbr,
   output logic                      busy,
   output logic                      step,
   output logic                      done,
   output logic [2*WIDTH-1:0]        x_out,
   output logic [2*WIDTH-1:0]        y_out
);

   localparam int XW = 2*WIDTH;
   localparam int PW = 3*WIDTH;
   // Sized so nine full-scale products plus bias and state can never wrap.
   localparam int AW = 3*WIDTH + $clog2(2*TAPS) + 1;
   localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

   localparam logic signed [AW-1:0] X_MAX = AW'((2**(XW-1)) - 1);
   localparam logic signed [AW-1:0] X_MIN = AW'(-(2**(XW-1)));
   localparam logic signed [XW-1:0] Y_MAX = XW'(2**FRAC);
   localparam logic signed [XW-1:0] Y_MIN = XW'(-(2**FRAC));

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_UPD, S_FIN} state_t;

   state_t                  state;
   logic [TAPS*WIDTH-1:0]   a_r, b_r, u_r;
   logic [TAPS*XW-1:0]      y_r;
   logic signed [WIDTH-1:0] bias_r;
   logic [ITW-1:0]          n_r;
   logic [ITW-1:0]          iter;
   logic [KW-1:0]           k;
   logic signed [AW-1:0]    acc;
   logic signed [XW-1:0]    x_r;

   logic signed [WIDTH-1:0] a_k, b_k, u_k;
   logic signed [XW-1:0]    y_k;
   logic signed [PW-1:0]    prod_a, prod_b;
   logic signed [AW-1:0]    mac_term;
   logic signed [AW-1:0]    d_val, x_sum;
   logic signed [XW-1:0]    x_next;

   // Clamp a wide intermediate into the signed state range.
   function automatic logic signed [XW-1:0] sat_x(input logic signed [AW-1:0] v);
      if (v > X_MAX)
         return XW'(X_MAX);
      else if (v < X_MIN)
         return XW'(X_MIN);
      else
         return XW'(v);
   endfunction

   // Cell output nonlinearity: clamp to [-1.0, +1.0] in FRAC fixed point.
   function automatic logic [XW-1:0] sat_y(input logic signed [XW-1:0] v);
      if (v > Y_MAX)
         return Y_MAX;
      else if (v < Y_MIN)
         return Y_MIN;
      else
         return v;
   endfunction

   assign x_out = x_r;

   // Select tap k and form its two rescaled products (shifts floor toward -inf).
   always_comb begin
      a_k      = $signed(a_r[k*WIDTH +: WIDTH]);
      b_k      = $signed(b_r[k*WIDTH +: WIDTH]);
      u_k      = $signed(u_r[k*WIDTH +: WIDTH]);
      y_k      = $signed(y_r[k*XW +: XW]);
      prod_a   = PW'(a_k) * PW'(y_k);
      prod_b   = PW'(b_k) * PW'(u_k);
      mac_term = AW'(prod_a >>> FRAC) + AW'(prod_b >>> FRAC);
   end

   // Euler update candidate: x + (acc + I - x) * 2^-DT_SHIFT, saturated.
   always_comb begin
      d_val  = acc + AW'(bias_r) - AW'(x_r);
      x_sum  = AW'(x_r) + (d_val >>> DT_SHIFT);
      x_next = sat_x(x_sum);
   end

   // Control FSM and datapath registers; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         a_r    <= '0;
         b_r    <= '0;
         u_r    <= '0;
         y_r    <= '0;
         bias_r <= '0;
         n_r    <= '0;
         iter   <= '0;
         k      <= '0;
         acc    <= '0;
         x_r    <= '0;
         y_out  <= '0;
         busy   <= 1'b0;
         step   <= 1'b0;
         done   <= 1'b0;
      end else begin
         step <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_r    <= a_flat;
                  b_r    <= b_flat;
                  u_r    <= u_flat;
                  bias_r <= $signed(bias);
                  n_r    <= n_iter;
                  x_r    <= $signed(x_init);
                  y_out  <= sat_y($signed(x_init));
                  busy   <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               y_r  <= y_nbr;
               acc  <= '0;
               k    <= '0;
               iter <= '0;
               if (n_r == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_FIN;
               end else begin
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc + mac_term;
               if (k == KW'(TAPS-1)) begin
                  k     <= '0;
                  state <= S_UPD;
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_UPD: begin
               x_r   <= x_next;
               y_out <= sat_y(x_next);
               step  <= 1'b1;
               iter  <= iter + 1'b1;
               y_r   <= y_nbr;
               acc   <= '0;
               k     <= '0;
               if (iter + 1'b1 == n_r) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_FIN;
               end else begin
                  state <= S_MAC;
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_cell_euler_iter.sv
// Bench for cnn_cell_euler_iter: directed scenarios plus randomized runs against an arithmetic model.
// Latency, busy window, step pulses and final state are all checked per run.
// Inputs are driven and outputs sampled on the falling edge.
module tb_cnn_cell_euler_iter;

   localparam int WIDTH = 9;
   localparam int TAPS  = 9;
   localparam int FRAC  = 4;
   localparam int ITW   = 8;
   localparam int XW    = 2*WIDTH;
   localparam int MAXN  = 6;

   logic                    clk;
   logic                    reset;
   logic                    start;
   logic [ITW-1:0]          n_iter;
   logic [TAPS*WIDTH-1:0]   a_flat, b_flat, u_flat;
   logic [WIDTH-1:0]        bias;
   logic [XW-1:0]           x_init;
   logic [TAPS*XW-1:0]      y_nbr;
   logic                    busy, step, done;
   logic [XW-1:0]           x_out, y_out;

   cnn_cell_euler_iter dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .n_iter (n_iter),
      .a_flat (a_flat),
      .b_flat (b_flat),
      .u_flat (u_flat),
      .bias   (bias),
      .x_init (x_init),
      .y_nbr  (y_nbr),
      .busy   (busy),
      .step   (step),
      .done   (done),
      .x_out  (x_out),
      .y_out  (y_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scenario configuration (signed integer view of every input)
   int a_t [TAPS];
   int b_t [TAPS];
   int u_t [TAPS];
   int bias_t;
   int xinit_t;
   int ys [MAXN+2][TAPS];
   int exp_x[$];

   // Observations from the most recent run
   logic [XW-1:0] obs_x[$];
   logic [XW-1:0] obs_y[$];
   int            obs_lat;
   int            obs_busy_cnt;
   logic          obs_busy_done;
   logic          obs_got;
   logic [XW-1:0] idle_x, idle_y;

   // ---------------- reference model ----------------
   function automatic longint fdiv(input longint v, input longint m);
      longint q;
      q = v / m;
      if ((v % m) != 0 && v < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint clampl(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic void model_run(input int n);
      longint x, acc, d;
      x = xinit_t;
      exp_x.delete();
      for (int j = 0; j < n; j++) begin
         acc = 0;
         for (int t = 0; t < TAPS; t++) begin
            acc = acc + fdiv(longint'(a_t[t]) * longint'(ys[j][t]), 16)
                      + fdiv(longint'(b_t[t]) * longint'(u_t[t]), 16);
         end
         d = acc + bias_t - x;
         x = clampl(x + fdiv(d, 2), -131072, 131071);
         exp_x.push_back(int'(x));
      end
   endfunction

   function automatic int yclamp(input int v);
      return int'(clampl(v, -16, 16));
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic clear_cfg();
      for (int t = 0; t < TAPS; t++) begin
         a_t[t] = 0; b_t[t] = 0; u_t[t] = 0;
         for (int j = 0; j < MAXN+2; j++) ys[j][t] = 0;
      end
      bias_t  = 0;
      xinit_t = 0;
   endtask

   task automatic set_y(input int j);
      for (int t = 0; t < TAPS; t++) y_nbr[t*XW +: XW] = XW'(ys[j][t]);
   endtask

   task automatic load_inputs(input int n);
      for (int t = 0; t < TAPS; t++) begin
         a_flat[t*WIDTH +: WIDTH] = WIDTH'(a_t[t]);
         b_flat[t*WIDTH +: WIDTH] = WIDTH'(b_t[t]);
         u_flat[t*WIDTH +: WIDTH] = WIDTH'(u_t[t]);
      end
      bias   = WIDTH'(bias_t);
      x_init = XW'(xinit_t);
      n_iter = ITW'(n);
      set_y(0);
   endtask

   task automatic scramble();
      for (int t = 0; t < TAPS; t++) begin
         a_flat[t*WIDTH +: WIDTH] = WIDTH'($urandom);
         b_flat[t*WIDTH +: WIDTH] = WIDTH'($urandom);
         u_flat[t*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      bias   = WIDTH'($urandom);
      x_init = XW'($urandom);
      n_iter = ITW'($urandom);
   endtask

   // Runs one start..done sequence (called on a falling edge while idle) and records what it sees.
   task automatic do_run(input int n, input bit inject);
      int budget;
      budget = 2 + n*(TAPS+1) + 20;
      obs_x.delete();
      obs_y.delete();
      obs_got = 1'b0;
      obs_lat = -1;
      obs_busy_cnt = 0;
      obs_busy_done = 1'bx;
      load_inputs(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         if (busy === 1'b1) obs_busy_cnt++;
         if (step === 1'b1) begin
            obs_x.push_back(x_out);
            obs_y.push_back(y_out);
            if (obs_x.size() + 1 < MAXN + 2) set_y(obs_x.size() + 1);
         end
         if (done === 1'b1) begin
            obs_got = 1'b1;
            obs_lat = c;
            obs_busy_done = busy;
            break;
         end
         if (c == 2) begin
            set_y(1);
            scramble();
         end
         start = (inject && c == 5);
         @(negedge clk);
      end
      start = 1'b0;
      if (obs_got) begin
         @(negedge clk);
         idle_x = x_out;
         idle_y = y_out;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (x_out !== '0) begin errors++; $display("FAIL reset_x: got %0d expected 0", $signed(x_out)); end
      checks++; if (y_out !== '0) begin errors++; $display("FAIL reset_y: got %0d expected 0", $signed(y_out)); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_bias_only();
      int ex [5] = '{8, 12, 14, 15, 15};
      clear_cfg();
      bias_t = 16;
      do_run(5, 1'b0);
      checks++; if (obs_got !== 1'b1) begin errors++; $display("FAIL t1_done: got %b expected 1", obs_got); end
      checks++; if (obs_lat != 52) begin errors++; $display("FAIL t1_latency: got %0d expected 52", obs_lat); end
      checks++; if (obs_busy_cnt != 51) begin errors++; $display("FAIL t1_busy_cycles: got %0d expected 51", obs_busy_cnt); end
      checks++; if (obs_busy_done !== 1'b0) begin errors++; $display("FAIL t1_busy_at_done: got %b expected 0", obs_busy_done); end
      checks++; if (obs_x.size() != 5) begin errors++; $display("FAIL t1_steps: got %0d expected 5", obs_x.size()); end
      for (int i = 0; i < obs_x.size() && i < 5; i++) begin
         checks++;
         if (obs_x[i] !== XW'(ex[i])) begin
            errors++; $display("FAIL t1_x_step%0d: got %0d expected %0d", i, $signed(obs_x[i]), ex[i]);
         end
      end
      checks++; if (idle_x !== XW'(15)) begin errors++; $display("FAIL t1_hold_x: got %0d expected 15", $signed(idle_x)); end
      checks++; if (idle_y !== XW'(15)) begin errors++; $display("FAIL t1_y: got %0d expected 15", $signed(idle_y)); end
   endtask

   task automatic test_clamp_output();
      clear_cfg();
      bias_t  = 16;
      xinit_t = 100;
      do_run(1, 1'b0);
      checks++; if (obs_lat != 12) begin errors++; $display("FAIL t2_latency: got %0d expected 12", obs_lat); end
      checks++; if (obs_x.size() != 1) begin errors++; $display("FAIL t2_steps: got %0d expected 1", obs_x.size()); end
      checks++; if (idle_x !== XW'(58)) begin errors++; $display("FAIL t2_x: got %0d expected 58", $signed(idle_x)); end
      checks++; if (idle_y !== XW'(16)) begin errors++; $display("FAIL t2_y: got %0d expected 16", $signed(idle_y)); end
   endtask

   task automatic test_feedback_centre();
      clear_cfg();
      a_t[TAPS/2]  = 32;
      ys[0][TAPS/2] = 16;
      do_run(1, 1'b0);
      checks++; if (obs_y.size() != 1 || obs_y[0] !== XW'(16)) begin
         errors++; $display("FAIL t3_step_y: got %0d pulses expected 1 with y 16", obs_y.size());
      end
      checks++; if (idle_x !== XW'(16)) begin errors++; $display("FAIL t3_x: got %0d expected 16", $signed(idle_x)); end
      checks++; if (idle_y !== XW'(16)) begin errors++; $display("FAIL t3_y: got %0d expected 16", $signed(idle_y)); end
   endtask

   task automatic test_zero_iter();
      clear_cfg();
      xinit_t = -40;
      a_t[0]  = 100;
      bias_t  = 50;
      do_run(0, 1'b0);
      checks++; if (obs_lat != 2) begin errors++; $display("FAIL t4_latency: got %0d expected 2", obs_lat); end
      checks++; if (obs_x.size() != 0) begin errors++; $display("FAIL t4_steps: got %0d expected 0", obs_x.size()); end
      checks++; if (obs_busy_cnt != 1) begin errors++; $display("FAIL t4_busy_cycles: got %0d expected 1", obs_busy_cnt); end
      checks++; if (idle_x !== XW'(-40)) begin errors++; $display("FAIL t4_x: got %0d expected -40", $signed(idle_x)); end
      checks++; if (idle_y !== XW'(-16)) begin errors++; $display("FAIL t4_y: got %0d expected -16", $signed(idle_y)); end
   endtask

   task automatic test_reset_abort();
      logic seen;
      clear_cfg();
      bias_t  = 16;
      xinit_t = 100;
      load_inputs(5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_before: got %b expected 1", busy); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy_after: got %b expected 0", busy); end
      checks++; if (x_out !== '0) begin errors++; $display("FAIL t5_x_after: got %0d expected 0", $signed(x_out)); end
      checks++; if (y_out !== '0) begin errors++; $display("FAIL t5_y_after: got %0d expected 0", $signed(y_out)); end
      reset = 1'b0;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1 || step === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t5_no_done: got activity %b expected 0", seen); end
   endtask

   task automatic test_start_ignored();
      clear_cfg();
      bias_t  = 16;
      do_run(5, 1'b1);
      checks++; if (obs_lat != 52) begin errors++; $display("FAIL t5_inject_latency: got %0d expected 52", obs_lat); end
      checks++; if (idle_x !== XW'(15)) begin errors++; $display("FAIL t5_inject_x: got %0d expected 15", $signed(idle_x)); end
      checks++; if (obs_x.size() != 5) begin errors++; $display("FAIL t5_inject_steps: got %0d expected 5", obs_x.size()); end
   endtask

   task automatic test_saturation();
      clear_cfg();
      for (int t = 0; t < TAPS; t++) begin
         a_t[t] = 255; b_t[t] = 255; u_t[t] = 255;
         for (int j = 0; j < MAXN+2; j++) ys[j][t] = 131071;
      end
      bias_t = 255;
      do_run(3, 1'b0);
      checks++; if (obs_x.size() != 3) begin errors++; $display("FAIL t6_steps: got %0d expected 3", obs_x.size()); end
      for (int i = 0; i < obs_x.size(); i++) begin
         checks++;
         if (obs_x[i] !== XW'(131071) || obs_y[i] !== XW'(16)) begin
            errors++; $display("FAIL t6_sat_step%0d: got x %0d y %0d expected x 131071 y 16", i, $signed(obs_x[i]), $signed(obs_y[i]));
         end
      end
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 14; r++) begin
         clear_cfg();
         for (int t = 0; t < TAPS; t++) begin
            a_t[t] = $urandom_range(0, 511) - 256;
            b_t[t] = $urandom_range(0, 511) - 256;
            u_t[t] = $urandom_range(0, 511) - 256;
            for (int j = 0; j < MAXN+2; j++)
               ys[j][t] = (r % 2 == 0) ? ($urandom_range(0, 32) - 16) : ($urandom_range(0, 262143) - 131072);
         end
         bias_t  = $urandom_range(0, 511) - 256;
         xinit_t = $urandom_range(0, 262143) - 131072;
         n = $urandom_range(0, MAXN);
         model_run(n);
         do_run(n, r % 3 == 1);
         checks++;
         if (obs_lat != 2 + n*(TAPS+1)) begin
            errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, obs_lat, 2 + n*(TAPS+1));
         end
         checks++;
         if (obs_busy_cnt != 1 + n*(TAPS+1) || obs_busy_done !== 1'b0) begin
            errors++; $display("FAIL rand%0d_busy: got %0d cycles expected %0d", r, obs_busy_cnt, 1 + n*(TAPS+1));
         end
         checks++;
         if (obs_x.size() != n) begin
            errors++; $display("FAIL rand%0d_steps: got %0d expected %0d", r, obs_x.size(), n);
         end
         for (int i = 0; i < obs_x.size() && i < n; i++) begin
            checks++;
            if (obs_x[i] !== XW'(exp_x[i]) || obs_y[i] !== XW'(yclamp(exp_x[i]))) begin
               errors++;
               $display("FAIL rand%0d_step%0d: got x %0d y %0d expected x %0d y %0d", r, i,
                        $signed(obs_x[i]), $signed(obs_y[i]), exp_x[i], yclamp(exp_x[i]));
            end
         end
         checks++;
         if (idle_x !== XW'((n == 0) ? xinit_t : exp_x[n-1])) begin
            errors++; $display("FAIL rand%0d_hold_x: got %0d expected %0d", r, $signed(idle_x), (n == 0) ? xinit_t : exp_x[n-1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_cfg();
      bias_t = 16;
      do_run(1, 1'b0);
      xinit_t = -200;
      bias_t  = -100;
      model_run(2);
      do_run(2, 1'b0);
      checks++;
      if (obs_lat != 22) begin errors++; $display("FAIL b2b_latency: got %0d expected 22", obs_lat); end
      checks++;
      if (obs_x.size() != 2 || idle_x !== XW'(exp_x[1])) begin
         errors++; $display("FAIL b2b_x: got %0d expected %0d", $signed(idle_x), exp_x[1]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      n_iter = '0;
      a_flat = '0;
      b_flat = '0;
      u_flat = '0;
      bias   = '0;
      x_init = '0;
      y_nbr  = '0;
      test_reset();
      test_bias_only();
      test_clamp_output();
      test_feedback_centre();
      test_zero_iter();
      test_reset_abort();
      test_start_ignored();
      test_saturation();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
